// File: rtl/mmcm_drp_pkg.sv
// Shared DRP constants for MMCM/PLL counter access: register addresses,
// field bit positions and the readback FSM state encoding.
package mmcm_drp_pkg;

  // Same register map the reconfiguration writer uses
  localparam logic [6:0] CLKOUT0_REG1_ADDR  = 7'h08;
  localparam logic [6:0] CLKFBOUT_REG1_ADDR = 7'h14;
  localparam logic [6:0] DIVCLK_REG_ADDR    = 7'h16;

  localparam int NUM_READS = 5;

  // ClkReg1
  localparam int CR1_PHASE_MUX_LSB = 13;
  localparam int CR1_HIGH_LSB      = 6;
  localparam int CR1_LOW_LSB       = 0;

  // ClkReg2
  localparam int CR2_FRAC_LSB     = 12;
  localparam int CR2_FRAC_EN_BIT  = 11;
  localparam int CR2_WF_R_BIT     = 10;
  localparam int CR2_EDGE_BIT     = 7;
  localparam int CR2_NO_COUNT_BIT = 6;
  localparam int CR2_DELAY_LSB    = 0;

  // DivReg
  localparam int DIV_EDGE_BIT     = 13;
  localparam int DIV_NO_COUNT_BIT = 12;
  localparam int DIV_HIGH_LSB     = 6;
  localparam int DIV_LOW_LSB      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/mmcm_drp_readback_if.sv
// DRP bus between a requester (master) and the MMCM/PLL primitive (slave).
// Handshake: master pulses den for one cycle with daddr valid; the slave
// answers with a one-cycle drdy carrying drp_do. One request outstanding.
interface mmcm_drp_readback_if;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy;

  modport master (output daddr, den, dwe, di, input drp_do, drdy);
  modport slave  (input daddr, den, dwe, di, output drp_do, drdy);
endinterface

// File: rtl/mmcm_clkreg_decode.sv
// Splits an output/feedback counter's ClkReg1/ClkReg2 pair into its fields.
module mmcm_clkreg_decode
  import mmcm_drp_pkg::*;
(
  input  logic [15:0] reg1,
  input  logic [15:0] reg2,
  output logic [5:0]  high_time,
  output logic [5:0]  low_time,
  output logic [5:0]  delay_time,
  output logic [2:0]  phase_mux,
  output logic [2:0]  frac,
  output logic        frac_en,
  output logic        wf_r,
  output logic        edge_en,
  output logic        no_count
);

  assign phase_mux  = reg1[CR1_PHASE_MUX_LSB +: 3];
  assign high_time  = reg1[CR1_HIGH_LSB +: 6];
  assign low_time   = reg1[CR1_LOW_LSB +: 6];

  assign frac       = reg2[CR2_FRAC_LSB +: 3];
  assign frac_en    = reg2[CR2_FRAC_EN_BIT];
  assign wf_r       = reg2[CR2_WF_R_BIT];
  assign edge_en    = reg2[CR2_EDGE_BIT];
  assign no_count   = reg2[CR2_NO_COUNT_BIT];
  assign delay_time = reg2[CR2_DELAY_LSB +: 6];

  // Reserved bits carry nothing we expose
  logic unused_reserved;
  assign unused_reserved = ^{reg1[12], reg2[15], reg2[9:8]};

endmodule

// File: rtl/mmcm_drp_readback.sv
// Reads the five MMCM counter registers over DRP and presents the decoded
// fields; outputs change only when a full sequence completes.
module mmcm_drp_readback
  import mmcm_drp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [6:0]  CLKOUT0_ADDR   = CLKOUT0_REG1_ADDR,
  parameter logic [6:0]  CLKFBOUT_ADDR  = CLKFBOUT_REG1_ADDR,
  parameter logic [6:0]  DIVCLK_ADDR    = DIVCLK_REG_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ready,
  output logic       done,
  output logic       timeout_err,
  mmcm_drp_readback_if.master drp,
  output logic [5:0] CLKOUT0_HIGH_TIME,
  output logic [5:0] CLKOUT0_LOW_TIME,
  output logic [5:0] CLKOUT0_DELAY_TIME,
  output logic [2:0] CLKOUT0_PHASE_MUX,
  output logic [2:0] CLKOUT0_FRAC,
  output logic       CLKOUT0_FRAC_EN,
  output logic       CLKOUT0_WF_R,
  output logic       CLKOUT0_EDGE,
  output logic       CLKOUT0_NO_COUNT,
  output logic [5:0] CLKFBOUT_HIGH_TIME,
  output logic [5:0] CLKFBOUT_LOW_TIME,
  output logic [5:0] CLKFBOUT_DELAY_TIME,
  output logic [2:0] CLKFBOUT_PHASE_MUX,
  output logic [2:0] CLKFBOUT_FRAC,
  output logic       CLKFBOUT_FRAC_EN,
  output logic       CLKFBOUT_WF_R,
  output logic       CLKFBOUT_EDGE,
  output logic       CLKFBOUT_NO_COUNT,
  output logic [5:0] DIVCLK_HIGH_TIME,
  output logic [5:0] DIVCLK_LOW_TIME,
  output logic       DIVCLK_EDGE,
  output logic       DIVCLK_NO_COUNT,
  output state_t     state_dbg
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [2:0]  idx;
  logic [7:0]  timer;
  logic        den_q;
  logic        done_q;
  logic        terr_q;
  logic [6:0]  daddr_q;
  logic [15:0] shadow [NUM_READS];
  logic [15:0] live   [NUM_READS];

  function automatic logic [6:0] addr_of(input logic [2:0] i);
    case (i)
      3'd0:    return CLKOUT0_ADDR;
      3'd1:    return CLKOUT0_ADDR + 7'd1;
      3'd2:    return CLKFBOUT_ADDR;
      3'd3:    return CLKFBOUT_ADDR + 7'd1;
      default: return DIVCLK_ADDR;
    endcase
  endfunction

  // den/done are set on the transition into ISSUE/FINISH so each lasts one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      timer   <= '0;
      den_q   <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      daddr_q <= '0;
      for (int i = 0; i < NUM_READS; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else begin
      den_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            terr_q  <= 1'b0;
            idx     <= '0;
            daddr_q <= addr_of(3'd0);
            den_q   <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // drdy takes priority over an expiring timer
          if (drp.drdy) begin
            shadow[idx] <= drp.drp_do;
            if (idx == 3'd4) begin
              state <= ST_COMMIT;
            end else begin
              idx     <= idx + 3'd1;
              daddr_q <= addr_of(idx + 3'd1);
              den_q   <= 1'b1;
              state   <= ST_ISSUE;
            end
          end else if (timer == TIMER_LAST) begin
            terr_q <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_FINISH;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_COMMIT: begin
          for (int i = 0; i < NUM_READS; i++) live[i] <= shadow[i];
          done_q <= 1'b1;
          state  <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign ready       = (state == ST_IDLE);
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign state_dbg   = state;

  assign drp.daddr = daddr_q;
  assign drp.den   = den_q;
  assign drp.dwe   = 1'b0;
  assign drp.di    = '0;

  mmcm_clkreg_decode u_clkout0 (
    .reg1       (live[0]),
    .reg2       (live[1]),
    .high_time  (CLKOUT0_HIGH_TIME),
    .low_time   (CLKOUT0_LOW_TIME),
    .delay_time (CLKOUT0_DELAY_TIME),
    .phase_mux  (CLKOUT0_PHASE_MUX),
    .frac       (CLKOUT0_FRAC),
    .frac_en    (CLKOUT0_FRAC_EN),
    .wf_r       (CLKOUT0_WF_R),
    .edge_en    (CLKOUT0_EDGE),
    .no_count   (CLKOUT0_NO_COUNT)
  );

  mmcm_clkreg_decode u_clkfbout (
    .reg1       (live[2]),
    .reg2       (live[3]),
    .high_time  (CLKFBOUT_HIGH_TIME),
    .low_time   (CLKFBOUT_LOW_TIME),
    .delay_time (CLKFBOUT_DELAY_TIME),
    .phase_mux  (CLKFBOUT_PHASE_MUX),
    .frac       (CLKFBOUT_FRAC),
    .frac_en    (CLKFBOUT_FRAC_EN),
    .wf_r       (CLKFBOUT_WF_R),
    .edge_en    (CLKFBOUT_EDGE),
    .no_count   (CLKFBOUT_NO_COUNT)
  );

  assign DIVCLK_EDGE      = live[4][DIV_EDGE_BIT];
  assign DIVCLK_NO_COUNT  = live[4][DIV_NO_COUNT_BIT];
  assign DIVCLK_HIGH_TIME = live[4][DIV_HIGH_LSB +: 6];
  assign DIVCLK_LOW_TIME  = live[4][DIV_LOW_LSB +: 6];

  logic unused_div_reserved;
  assign unused_div_reserved = ^live[4][15:14];

endmodule
